sram_ctrl: RTL and testbench

Pipelined Wishbone B4 slave that bridges the memory arbiter's master port to a single-port, asynchronous-style external or on-chip SRAM with programmable wait states. It sits directly downstream of the two-port memory arbiter and owns the `m_wb_*` side of that block. It serialises one access at a time, drives the SRAM control and byte-enable lines for a fixed number of cycles, and returns read data with a single-cycle ack.

---
 rtl/sram_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sram_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: pipelined Wishbone B4 slave in front of a single-port SRAM.
// It accepts one request at a time. The SRAM control, address, byte-enable and
// write-data lines are held for WAIT_STATES+1 cycles. Read data comes back
// with a single-cycle ack.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   wb_adr_i            byte address; word address = wb_adr_i[ADDR_W+1:2]
//   wb_dat_i/wb_dat_o   write data in / read data out (nonzero only with ack)
//   wb_we_i, wb_sel_i   write flag, byte lane select
//   wb_stb_i, wb_cyc_i  strobe, cycle
//   wb_ack_o            single-cycle acknowledge
//   wb_stall_o          high whenever the controller is not idle
//   sram_addr_o         SRAM word address
//   sram_data_o         SRAM write data
//   sram_data_i         SRAM read data
//   sram_ce_o           chip enable
//   sram_we_o           write enable
//   sram_be_o           byte enables
module sram_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic              wb_stall_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i,
  output logic              sram_ce_o,
  output logic              sram_we_o,
  output logic [3:0]        sram_be_o
);

  localparam int CLOG_W = $clog2(WAIT_STATES + 1);
  localparam int CNT_W  = (CLOG_W > 1) ? CLOG_W : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                abort_r, abort_s;
  logic [31:0]         rd_data_r, rd_data_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [31:0]         wdat_r, wdat_s;
  logic                we_r, we_s;
  logic [3:0]          sel_r, sel_s;
  logic                ack_s;

  // Upper and byte-offset address bits are intentionally discarded (address wrap).
  logic                adr_unused_s;
  assign adr_unused_s = ^{wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0]};

  // State and request registers; reset abandons any access in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      abort_r   <= 1'b0;
      rd_data_r <= 32'h0000_0000;
      addr_r    <= {ADDR_W{1'b0}};
      wdat_r    <= 32'h0000_0000;
      we_r      <= 1'b0;
      sel_r     <= 4'b0000;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      abort_r   <= abort_s;
      rd_data_r <= rd_data_s;
      addr_r    <= addr_s;
      wdat_r    <= wdat_s;
      we_r      <= we_s;
      sel_r     <= sel_s;
    end
  end

  // Next-state logic: accept in IDLE, count wait states in ACCESS, one ACK cycle.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    abort_s   = abort_r;
    rd_data_s = rd_data_r;
    addr_s    = addr_r;
    wdat_s    = wdat_r;
    we_s      = we_r;
    sel_s     = sel_r;
    case (state_r)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          addr_s  = wb_adr_i[ADDR_W+1:2];
          wdat_s  = wb_dat_i;
          we_s    = wb_we_i;
          sel_s   = wb_sel_i;
          cnt_s   = CNT_LOAD;
          abort_s = 1'b0;
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // A dropped cycle only suppresses the ack; the SRAM access runs to completion.
        if (!wb_cyc_i) begin
          abort_s = 1'b1;
        end else begin
          abort_s = abort_r;
        end
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_s   = cnt_r - CNT_ONE;
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_ACK;
          if (!we_r) begin
            rd_data_s = sram_data_i;
          end else begin
            rd_data_s = rd_data_r;
          end
        end
      end
      ST_ACK: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the state register; SRAM lines are quiet outside ACCESS.
  always_comb begin
    ack_s = (state_r == ST_ACK) && !abort_r && wb_cyc_i;
    if (state_r == ST_ACCESS) begin
      sram_ce_o   = 1'b1;
      sram_we_o   = we_r;
      sram_be_o   = sel_r;
      sram_addr_o = addr_r;
      sram_data_o = wdat_r;
    end else begin
      sram_ce_o   = 1'b0;
      sram_we_o   = 1'b0;
      sram_be_o   = 4'b0000;
      sram_addr_o = {ADDR_W{1'b0}};
      sram_data_o = 32'h0000_0000;
    end
    if (ack_s && !we_r) begin
      wb_dat_o = rd_data_r;
    end else begin
      wb_dat_o = 32'h0000_0000;
    end
  end

  assign wb_ack_o   = ack_s;
  assign wb_stall_o = (state_r != ST_IDLE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: a cycle table, directed multi-cycle
// sequences and randomized transfers checked against a transaction-level model.
module tb_sram_ctrl;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (WAIT_STATES=2)
  logic [31:0] wb_adr = 32'h0, wb_dat = 32'h0, wb_dat_o;
  logic        wb_we = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0, wb_ack_o, wb_stall_o;
  logic [3:0]  wb_sel = 4'h0;
  logic [15:0] sram_addr_o;
  logic [31:0] sram_data_o, sram_data_i;
  logic        sram_ce_o, sram_we_o;
  logic [3:0]  sram_be_o;

  sram_ctrl #(.ADDR_W(16), .WAIT_STATES(WS)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we), .wb_sel_i(wb_sel), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc),
    .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
    .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
    .sram_ce_o(sram_ce_o), .sram_we_o(sram_we_o), .sram_be_o(sram_be_o)
  );

  // Second instance (WAIT_STATES=0)
  logic [31:0] adr0 = 32'h0, dat0 = 32'h0, dat0_o;
  logic        we0 = 1'b0, stb0 = 1'b0, cyc0 = 1'b0, ack0, stall0;
  logic [3:0]  sel0 = 4'h0;
  logic [15:0] saddr0;
  logic [31:0] sdata0_o, sdata0_i;
  logic        ce0, swe0;
  logic [3:0]  be0;

  sram_ctrl #(.ADDR_W(16), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .wb_adr_i(adr0), .wb_dat_i(dat0), .wb_dat_o(dat0_o),
    .wb_we_i(we0), .wb_sel_i(sel0), .wb_stb_i(stb0), .wb_cyc_i(cyc0),
    .wb_ack_o(ack0), .wb_stall_o(stall0),
    .sram_addr_o(saddr0), .sram_data_o(sdata0_o), .sram_data_i(sdata0_i),
    .sram_ce_o(ce0), .sram_we_o(swe0), .sram_be_o(be0)
  );
  assign sdata0_i = {16'hC0DE, saddr0};

  // Power-up SRAM contents, shared by the SRAM model and the reference model.
  function automatic logic [31:0] init_word(input logic [15:0] a);
    if (a == 16'h0010)      return 32'hDEAD_BEEF;
    else if (a == 16'h0002) return 32'h1234_5678;
    else                    return {a ^ 16'hA5C3, ~a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // SRAM model: combinational read, byte-masked write while ce&we at each edge.
  bit [31:0] sram_mem [65536];
  bit        sram_wv  [65536];
  always_comb sram_data_i = sram_wv[sram_addr_o] ? sram_mem[sram_addr_o] : init_word(sram_addr_o);
  always @(posedge clk) begin
    if (sram_ce_o && sram_we_o) begin
      sram_mem[sram_addr_o] <= merge(sram_data_i, sram_data_o, sram_be_o);
      sram_wv[sram_addr_o]  <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {40'h0, wb_ack_o, wb_dat_o, wb_stall_o, sram_ce_o, sram_we_o, sram_be_o,
            sram_addr_o, sram_data_o};
  endfunction

  typedef struct {
    logic cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic ack;
    logic [31:0] dat_o;
    logic stall, ce, swe;
    logic [3:0]  be;
    logic [15:0] saddr;
    logic [31:0] sdata;
  } vec_t;

  function automatic vec_t mkv(logic cyc, logic stb, logic we, logic [31:0] adr, logic [31:0] dat,
                               logic [3:0] sel, logic ack, logic [31:0] dat_o, logic stall,
                               logic ce, logic swe, logic [3:0] be, logic [15:0] saddr,
                               logic [31:0] sdata);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
    v.ack = ack; v.dat_o = dat_o; v.stall = stall; v.ce = ce; v.swe = swe;
    v.be = be; v.saddr = saddr; v.sdata = sdata;
    return v;
  endfunction

  // One transfer on the main instance, starting and ending at a negedge.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata,
                         output int lat, output int ce_cycles, output int acks);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    for (int i = 0; i < 20 && wb_stall_o; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    wb_stb = 1'b0;
    lat = -1; ce_cycles = 0; acks = 0; rdata = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (sram_ce_o) ce_cycles++;
      if (wb_ack_o) begin acks++; rdata = wb_dat_o; lat = c; end
      @(negedge clk);
    end
    wb_cyc = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] rd, exp_d;
    int lat, cec, acks;
    logic [31:0] ref_mem [16];

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    check("reset_outputs", outs(), 128'h0);
    check("reset_outputs_ws0", {ack0, dat0_o, stall0, ce0, swe0, be0, saddr0, sdata0_o}, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // Cycle table: read 0x40, write 0x8, read-back 0x8, read with cyc low in ACK
    vecs.push_back(mkv(1,1,0,32'h40,32'h0,4'hF, 0,32'h0,0, 0,0,4'h0,16'h0,32'h0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv(1,0,0,32'h40,32'h0,4'hF, 0,32'h0,1, 1,0,4'hF,16'h10,32'h0));
    vecs.push_back(mkv(1,0,0,32'h40,32'h0,4'hF, 1,32'hDEADBEEF,1, 0,0,4'h0,16'h0,32'h0));
    vecs.push_back(mkv(0,0,0,32'h0,32'h0,4'h0, 0,32'h0,0, 0,0,4'h0,16'h0,32'h0));
    vecs.push_back(mkv(1,1,1,32'h8,32'hA5A5A5A5,4'h3, 0,32'h0,0, 0,0,4'h0,16'h0,32'h0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv(1,0,1,32'h8,32'hA5A5A5A5,4'h3, 0,32'h0,1, 1,1,4'h3,16'h2,32'hA5A5A5A5));
    vecs.push_back(mkv(1,0,1,32'h8,32'hA5A5A5A5,4'h3, 1,32'h0,1, 0,0,4'h0,16'h0,32'h0));
    vecs.push_back(mkv(0,0,0,32'h0,32'h0,4'h0, 0,32'h0,0, 0,0,4'h0,16'h0,32'h0));
    vecs.push_back(mkv(1,1,0,32'h8,32'h0,4'hF, 0,32'h0,0, 0,0,4'h0,16'h0,32'h0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv(1,0,0,32'h8,32'h0,4'hF, 0,32'h0,1, 1,0,4'hF,16'h2,32'h0));
    vecs.push_back(mkv(1,0,0,32'h8,32'h0,4'hF, 1,32'h1234A5A5,1, 0,0,4'h0,16'h0,32'h0));
    vecs.push_back(mkv(0,0,0,32'h0,32'h0,4'h0, 0,32'h0,0, 0,0,4'h0,16'h0,32'h0));
    vecs.push_back(mkv(1,1,0,32'h40,32'h0,4'hF, 0,32'h0,0, 0,0,4'h0,16'h0,32'h0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv(1,0,0,32'h40,32'h0,4'hF, 0,32'h0,1, 1,0,4'hF,16'h10,32'h0));
    vecs.push_back(mkv(0,0,0,32'h40,32'h0,4'hF, 0,32'h0,1, 0,0,4'h0,16'h0,32'h0));
    vecs.push_back(mkv(0,0,0,32'h0,32'h0,4'h0, 0,32'h0,0, 0,0,4'h0,16'h0,32'h0));

    foreach (vecs[i]) begin
      wb_cyc = vecs[i].cyc; wb_stb = vecs[i].stb; wb_we = vecs[i].we;
      wb_adr = vecs[i].adr; wb_dat = vecs[i].dat; wb_sel = vecs[i].sel;
      #1;
      check($sformatf("vec%0d", i), outs(),
            {40'h0, vecs[i].ack, vecs[i].dat_o, vecs[i].stall, vecs[i].ce, vecs[i].swe,
             vecs[i].be, vecs[i].saddr, vecs[i].sdata});
      @(posedge clk); @(negedge clk);
    end

    // Back-to-back: stb held for reads of 0x0 then 0x4
    begin
      int nacks, t1, t2, accepts, a2;
      logic acc;
      nacks = 0; t1 = -1; t2 = -1; accepts = 0; a2 = -1;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0; wb_sel = 4'hF;
      for (int c = 0; c < 20; c++) begin
        #1;
        acc = wb_stb && !wb_stall_o;
        if (wb_ack_o) begin
          if (nacks == 0) t1 = c; else t2 = c;
          nacks++;
        end
        @(posedge clk); @(negedge clk);
        if (acc) begin
          accepts++;
          if (accepts == 1) wb_adr = 32'h4;
          else begin wb_stb = 1'b0; a2 = c; end
        end
      end
      wb_cyc = 1'b0;
      check("b2b_ack_count", nacks, 2);
      check("b2b_ack_spacing", t2 - t1, 5);
      check("b2b_second_accept", a2 - t1, 1);
    end

    // Abort: cyc low in ACCESS cycles 2 and 3 of a write, back high in ACK
    begin
      int we_cnt, ack_cnt;
      logic st4, st5;
      we_cnt = 0; ack_cnt = 0; st4 = 1'b0; st5 = 1'b1;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'hC;
      wb_dat = 32'h11223344; wb_sel = 4'hF;
      @(posedge clk); @(negedge clk);
      wb_stb = 1'b0;
      for (int c = 1; c <= 6; c++) begin
        wb_cyc = (c == 2 || c == 3) ? 1'b0 : 1'b1;
        #1;
        if (sram_we_o) we_cnt++;
        if (wb_ack_o) ack_cnt++;
        if (c == 4) st4 = wb_stall_o;
        if (c == 5) st5 = wb_stall_o;
        @(posedge clk); @(negedge clk);
      end
      wb_cyc = 1'b0;
      check("abort_we_cycles", we_cnt, 3);
      check("abort_no_ack", ack_cnt, 0);
      check("abort_stall_in_ack", st4, 1'b1);
      check("abort_idle_at_n5", st5, 1'b0);
      wb_xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, lat, cec, acks);
      check("abort_write_landed", rd, 32'h11223344);
    end

    // Asynchronous reset in the middle of ACCESS
    begin
      int ack_cnt;
      ack_cnt = 0;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h40; wb_sel = 4'hF;
      @(posedge clk); @(negedge clk);
      wb_stb = 1'b0;
      @(posedge clk); @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_access_outputs", outs(), 128'h0);
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
        #1;
        if (wb_ack_o) ack_cnt++;
        @(negedge clk);
      end
      wb_cyc = 1'b0;
      check("rst_no_ack", ack_cnt, 0);
      wb_xfer(1'b0, 32'h0, 32'h0, 4'hF, rd, lat, cec, acks);
      check("rst_recover_timing", {lat, cec, acks}, {32'd4, 32'd3, 32'd1});
      check("rst_recover_data", rd, init_word(16'h0));
    end

    // Randomized transfers to words 0x100..0x10F against a transaction-level model
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(16'h100 + 16'(i));
    for (int k = 0; k < 150; k++) begin
      logic        we;
      logic [3:0]  widx, sel;
      logic [31:0] adr, dat;
      we   = 1'($urandom_range(0, 1));
      widx = 4'($urandom_range(0, 15));
      sel  = 4'($urandom_range(0, 15));
      dat  = $urandom;
      adr  = ($urandom & 32'hFFFC_0000) | ((32'h100 + {28'h0, widx}) << 2) | 32'($urandom_range(0, 3));
      exp_d = we ? 32'h0 : ref_mem[widx];
      if (we) ref_mem[widx] = merge(ref_mem[widx], dat, sel);
      wb_xfer(we, adr, dat, sel, rd, lat, cec, acks);
      check($sformatf("rnd%0d_timing", k), {lat, cec, acks}, {32'(WS + 2), 32'(WS + 1), 32'd1});
      check($sformatf("rnd%0d_data", k), rd, exp_d);
    end

    // WAIT_STATES=0 instance: address wrap and two-cycle latency
    cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b0; adr0 = 32'hFFFF_FFFC; sel0 = 4'hF; dat0 = 32'h0;
    #1;
    check("ws0_idle", {ack0, stall0, ce0}, 3'b000);
    @(posedge clk); @(negedge clk);
    stb0 = 1'b0;
    #1;
    check("ws0_access", {ack0, stall0, ce0, swe0, be0, saddr0, sdata0_o},
          {1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 16'hFFFF, 32'h0});
    @(posedge clk); @(negedge clk);
    #1;
    check("ws0_ack", {ack0, dat0_o, ce0, stall0}, {1'b1, 32'hC0DEFFFF, 1'b0, 1'b1});
    @(posedge clk); @(negedge clk);
    #1;
    check("ws0_back_idle", {ack0, stall0}, 2'b00);
    cyc0 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
